// File: rtl/population_uart_tx_if.sv
// Bundles the population handshake and UART status lines between the GA
// controller side (master) and the serializer (slave).
interface population_uart_tx_if #(
  parameter int POP_WIDTH = 7500
);
  logic                 start;
  logic [POP_WIDTH-1:0] population;
  logic                 tx;
  logic                 busy;
  logic                 done;
  logic [9:0]           byte_index;

  modport master (
    output start, population,
    input  tx, busy, done, byte_index
  );

  modport slave (
    input  start, population,
    output tx, busy, done, byte_index
  );
endinterface

// File: rtl/population_uart_tx.sv
// Serializes a latched GA population as 8N1 UART frames: one sync byte, then
// the population bytes LSB-first, triggered by a rising edge of start.
module population_uart_tx #(
  parameter int          POP_WIDTH    = 7500,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input logic                clk,
  input logic                rst,
  population_uart_tx_if.slave bus
);

  localparam int NUM_BYTES = (POP_WIDTH + 7) / 8;
  localparam int BUF_W     = NUM_BYTES * 8;
  localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [9:0]        LAST_IDX  = 10'(NUM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic               start_dly_q;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [2:0]         bit_nxt;
  logic [9:0]         idx_q, idx_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               trigger;
  logic               bit_end;
  logic [7:0]         cur_byte;

  assign trigger  = bus.start & ~start_dly_q & (state_q == S_IDLE);
  assign bit_end  = (baud_q == BAUD_LAST);
  assign bit_nxt  = bit_q + 3'd1;
  // The buffer is shifted down after each data frame, so the current data
  // byte is always in the low 8 bits; frame 0 is the sync header.
  assign cur_byte = (idx_q == 10'd0) ? SYNC_BYTE : buf_q[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trigger) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = (idx_q == LAST_IDX) ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_d = bit_end ? '0 : baud_q + 1'b1;
    bit_d  = bit_q;
    idx_d  = idx_q;
    buf_d  = buf_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = 3'd0;
        if (trigger) begin
          buf_d  = BUF_W'(bus.population);
          idx_d  = 10'd0;
          tx_d   = 1'b0;
          busy_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d = 3'd0;
          tx_d  = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
            idx_d  = 10'd0;
          end else begin
            tx_d  = 1'b0;
            idx_d = idx_q + 10'd1;
            if (idx_q != 10'd0) buf_d = buf_q >> 8;
          end
        end
      end
      default: begin
        baud_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_dly_q <= 1'b0;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      idx_q       <= 10'd0;
      buf_q       <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_dly_q <= bus.start;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.byte_index = idx_q;

endmodule

// File: tb/tb_population_uart_tx.sv
// Scoreboard bench for population_uart_tx: stimulus queues expected frames and
// done cycles; UART and done monitors pop and compare independently.
module tb_population_uart_tx;

  localparam int POP_W    = 20;
  localparam int CPB      = 4;
  localparam int NB       = 3;
  localparam int BUSY_CYC = (NB + 1) * 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  population_uart_tx_if #(.POP_WIDTH(POP_W)) bus();

  population_uart_tx #(
    .POP_WIDTH(POP_W),
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] exp_q[$];
  int          done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // UART receiver: samples mid-bit, counting from the first low sample.
  int         m_st = 0;
  int         m_cnt = 0;
  int         m_i = 0;
  logic [9:0] m_bits = '0;
  logic [9:0] m_idx = '0;
  logic [17:0] m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (bus.tx == 1'b0) begin
        m_st  = 1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if ((m_cnt % CPB) == (CPB / 2)) begin
        m_i = m_cnt / CPB;
        m_bits[m_i] = bus.tx;
        if (m_i == 0) m_idx = bus.byte_index;
        if (m_i == 9) begin
          m_st = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got byte 0x%0h expected no frame", m_bits[8:1]);
          end else begin
            m_exp = exp_q.pop_front();
            check("frame_byte", m_bits[8:1], m_exp[7:0]);
            check("frame_index", m_idx, m_exp[17:8]);
            check("frame_start_stop", {m_bits[9], m_bits[0]}, 2'b10);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
        check("busy_at_done", bus.busy, 1'b0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called with start low for at least one edge; leaves start high.
  task automatic trigger_xfer(input logic [19:0] pop, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    bus.population = pop;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    check("busy_on_trigger", bus.busy, 1'b1);
    check("tx_low_on_trigger", bus.tx, 1'b0);
    exp_q.push_back({10'd0, 8'hA5});
    exp_q.push_back({10'd1, b1});
    exp_q.push_back({10'd2, b2});
    exp_q.push_back({10'd3, b3});
    done_q.push_back(cyc + BUSY_CYC);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (bus.busy && n < maxc) begin
      step(1);
      n++;
    end
    check("idle_timeout", bus.busy, 1'b0);
  endtask

  int busy_seen;
  int n_wait;

  initial begin
    bus.start      = 1'b0;
    bus.population = '0;
    rst            = 1'b1;
    step(3);
    check("reset_outputs", {bus.tx, bus.busy, bus.done}, 3'b100);
    check("reset_index", bus.byte_index, 10'd0);
    rst = 1'b0;

    // Idle with start low
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_quiet", {bus.tx, bus.busy, bus.done}, 3'b100);
    end
    step(1);

    // Basic transfer
    trigger_xfer(20'hABCDE, 8'hDE, 8'hBC, 8'h0A);
    wait_idle(BUSY_CYC + 20);

    // Held start: no retrigger
    busy_seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("held_start_no_retrigger", busy_seen, 0);
    step(1);
    bus.start = 1'b0;
    step(2);
    trigger_xfer(20'hABCDE, 8'hDE, 8'hBC, 8'h0A);
    wait_idle(BUSY_CYC + 20);

    // Population changes after trigger
    bus.start = 1'b0;
    step(2);
    trigger_xfer(20'hABCDE, 8'hDE, 8'hBC, 8'h0A);
    bus.population = 20'h12345;
    wait_idle(BUSY_CYC + 20);

    // Start toggles during frame 2
    bus.start = 1'b0;
    step(2);
    trigger_xfer(20'hABCDE, 8'hDE, 8'hBC, 8'h0A);
    n_wait = 0;
    while (bus.byte_index != 10'd2 && n_wait < BUSY_CYC) begin
      step(1);
      n_wait++;
    end
    check("reach_frame2", bus.byte_index, 10'd2);
    bus.start = 1'b0; step(3);
    bus.start = 1'b1; step(3);
    bus.start = 1'b0; step(3);
    bus.start = 1'b1; step(2);
    bus.start = 1'b0;
    wait_idle(BUSY_CYC + 20);

    // Reset during data bits of frame 1
    step(2);
    trigger_xfer(20'hABCDE, 8'hDE, 8'hBC, 8'h0A);
    step(46);
    check("frame1_before_reset", bus.byte_index, 10'd1);
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    check("reset_mid_outputs", {bus.tx, bus.busy, bus.done}, 3'b100);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_mid_no_done", {bus.tx, bus.busy, bus.done}, 3'b100);
    end
    step(1);
    rst = 1'b0;
    step(2);
    trigger_xfer(20'hABCDE, 8'hDE, 8'hBC, 8'h0A);
    wait_idle(BUSY_CYC + 20);

    step(50);
    check("frames_all_seen", exp_q.size(), 0);
    check("dones_all_seen", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
